// File: rtl/mem_model.sv
// mem_model: single-outstanding line memory model with fixed or jittered
// response latency, aliasing-aware backing store and saturating statistics.
//
// Handshake: a request is taken in any cycle where mem_req_valid and
// mem_req_ready are both high. mem_req_ready is high only in IDLE, so at most
// one request is in flight. mem_resp_valid pulses for exactly one cycle at
// accept + L, and mem_resp_rdata holds its value until the next completion.
module mem_model #(
  parameter int ADDR_W  = 15,
  parameter int LINE_W  = 256,
  parameter int IDX_W   = 6,
  parameter int LAT_MIN = 20,
  parameter int JIT_EN  = 0,
  parameter int JIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_wdata,
  output logic              mem_req_ready,
  output logic              mem_resp_valid,
  output logic [LINE_W-1:0] mem_resp_rdata,
  input  logic              stats_clr,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [31:0]       busy_cycles
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int WORDS = LINE_W / 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic [15:0]       lfsr;
  logic [31:0]       cnt;
  logic [31:0]       lat_new;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;

  logic              accept;
  logic              fire;
  logic              src_rw;
  logic [ADDR_W-1:0] src_addr;
  logic [LINE_W-1:0] src_wdata;
  logic [IDX_W-1:0]  src_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [LINE_W-1:0] resp_line;

  logic [LINE_W-1:0] line_data [DEPTH];
  logic [ADDR_W-1:0] line_tag  [DEPTH];
  logic [DEPTH-1:0]  line_vld;

  // Fill pattern returned for lines that miss: word k = {k, 8'h00, addr}.
  function automatic logic [LINE_W-1:0] fill_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] f;
    f = '0;
    for (int k = 0; k < WORDS; k++) begin
      f[k*32 +: 32] = {8'(k), 8'h00, 16'(a)};
    end
    return f;
  endfunction

  assign mem_req_ready = (state == IDLE);
  assign accept        = mem_req_valid && mem_req_ready;
  assign wr_idx        = lat_addr[IDX_W-1:0];

  // Latency for a request accepted this cycle, using the current LFSR value.
  always_comb begin
    lat_new = 32'(LAT_MIN);
    if (JIT_EN != 0) begin
      lat_new = lat_new + 32'(lfsr[JIT_W-1:0]);
    end
  end

  // Response data is registered one edge early so it lines up with the pulse;
  // with L == 1 that edge is the accept edge itself, so use the live request.
  always_comb begin
    src_rw    = accept ? mem_req_rw    : lat_rw;
    src_addr  = accept ? mem_req_addr  : lat_addr;
    src_wdata = accept ? mem_req_wdata : lat_wdata;
    src_idx   = src_addr[IDX_W-1:0];
    fire      = (accept && (lat_new == 32'd1)) ||
                ((state == BUSY) && !mem_resp_valid && (cnt == 32'd1));
  end

  // Select completion data: write echoes wdata, read hits stored line or fills.
  always_comb begin
    resp_line = fill_line(src_addr);
    if (src_rw) begin
      resp_line = src_wdata;
    end else if (line_vld[src_idx] && (line_tag[src_idx] == src_addr)) begin
      resp_line = line_data[src_idx];
    end
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // IDLE/BUSY control: latch the request on accept, count down to the pulse,
  // return to IDLE on the edge that ends the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            lat_rw    <= mem_req_rw;
            lat_addr  <= mem_req_addr;
            lat_wdata <= mem_req_wdata;
            cnt       <= lat_new - 32'd1;
          end
        end
        BUSY: begin
          if (mem_resp_valid) begin
            state <= IDLE;
          end else if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response pulse and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
    end else begin
      mem_resp_valid <= fire;
      if (fire) begin
        mem_resp_rdata <= resp_line;
      end
    end
  end

  // Line valid bits: set when a write completes, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_vld <= '0;
    end else if (mem_resp_valid && lat_rw) begin
      line_vld[wr_idx] <= 1'b1;
    end
  end

  // Line data and tag storage, written in the write completion cycle.
  always_ff @(posedge clk) begin
    if (mem_resp_valid && lat_rw) begin
      line_data[wr_idx] <= lat_wdata;
      line_tag[wr_idx]  <= lat_addr;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      busy_cycles <= '0;
    end else if (stats_clr) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      busy_cycles <= '0;
    end else begin
      if (mem_resp_valid) begin
        if (lat_rw) begin
          if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end else begin
          if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        end
      end
      if ((state == BUSY) && (busy_cycles != 32'hFFFF_FFFF)) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_model.sv
// tb_mem_model: randomized scoreboard bench for mem_model with jitter enabled.
module tb_mem_model;

  localparam int AW   = 15;
  localparam int LW   = 256;
  localparam int LMIN = 20;
  localparam int JW   = 3;

  logic          clk;
  logic          rst_n;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
  logic          stats_clr;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;
  logic [31:0]   busy_cycles;

  mem_model #(
    .ADDR_W(AW), .LINE_W(LW), .IDX_W(6), .LAT_MIN(LMIN), .JIT_EN(1), .JIT_W(JW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .stats_clr(stats_clr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .busy_cycles(busy_cycles)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic [15:0] lfsr_m;
  logic [LW-1:0] m_data [64];
  logic [AW-1:0] m_tag  [64];
  bit            m_vld  [64];
  logic [LW-1:0] exp_q [$];
  int            exp_cyc_q [$];
  int  acc_cyc = 0, acc_l = 0;
  bit  outstanding = 0, held = 0, have_prev = 0;
  int  exp_rd = 0, exp_wr = 0, exp_busy = 0;
  bit  lat_seen [8];

  // Polynomial x^16+x^14+x^13+x^11+1: tap t feeds from bit 16-t, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int taps [4] = '{16, 14, 13, 11};
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [LW-1:0] fill(input logic [AW-1:0] a);
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = {8'(k), 8'h00, 1'b0, a};
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_next(lfsr_m);
  end

  // Called in the cycle where the DUT will take the request.
  task automatic model_accept(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d);
    int l;
    logic [LW-1:0] e;
    int idx;
    l = LMIN + int'(lfsr_m[JW-1:0]);
    lat_seen[l - LMIN] = 1'b1;
    if (held && have_prev) check("b2b_spacing", LW'(cyc - acc_cyc), LW'(acc_l + 1));
    idx = int'(a[5:0]);
    if (rw) begin
      e = d;
      m_data[idx] = d; m_tag[idx] = a; m_vld[idx] = 1'b1;
      exp_wr++;
    end else begin
      e = (m_vld[idx] && m_tag[idx] == a) ? m_data[idx] : fill(a);
      exp_rd++;
    end
    exp_busy += l;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + l);
    acc_cyc = cyc; acc_l = l; outstanding = 1'b1; have_prev = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [LW-1:0] e;
    int ec;
    bit exp_ready;
    if (rst_n) begin
      exp_ready = !(outstanding && cyc > acc_cyc && cyc <= acc_cyc + acc_l);
      check("req_ready", LW'(mem_req_ready), LW'(exp_ready));
      if (mem_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("resp_cycle", LW'(cyc), LW'(ec));
          check("resp_rdata", mem_resp_rdata, e);
          outstanding = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d);
    int w = 0;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = a; mem_req_wdata = d;
    while (!mem_req_ready && w < 200) begin @(negedge clk); w++; end
    if (!mem_req_ready) begin
      checks++;
      $display("FAIL accept_timeout: got ready=0 for 200 cycles expected ready=1");
      return;
    end
    model_accept(rw, a, d);
    @(negedge clk);
    held = 1'b1;
  endtask

  task automatic drop_idle();
    int w = 0;
    mem_req_valid = 1'b0;
    held = 1'b0;
    while ((exp_q.size() != 0 || !mem_req_ready) && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) begin
      checks++;
      $display("FAIL idle_timeout: got %0d pending responses expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_rd_cnt"}, LW'(rd_cnt), LW'(exp_rd));
    check({tag, "_wr_cnt"}, LW'(wr_cnt), LW'(exp_wr));
    check({tag, "_busy"},   LW'(busy_cycles), LW'(exp_busy));
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_busy = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LW-1:0] a5;
    logic [LW-1:0] d;
    logic [AW-1:0] a;
    logic          rw;
    int            w;
    a5 = {8{32'hA5A5A5A5}};
    rst_n = 1'b0; mem_req_valid = 1'b0; mem_req_rw = 1'b0;
    mem_req_addr = '0; mem_req_wdata = '0; stats_clr = 1'b0;
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < 8; i++) lat_seen[i] = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", LW'(mem_req_ready), LW'(1));
    check("rst_resp_valid", LW'(mem_resp_valid), LW'(0));
    check("rst_rdata", mem_resp_rdata, '0);
    check("rst_rd_cnt", LW'(rd_cnt), '0);
    check("rst_wr_cnt", LW'(wr_cnt), '0);
    check("rst_busy", LW'(busy_cycles), '0);

    // First request offered in the very cycle reset is released.
    rst_n = 1'b1;
    send(1'b0, 15'h0012, '0);
    drop_idle();
    check_counters("first");
    clear_stats();
    check_counters("clr_idle");

    // Write/read same line, then aliasing index.
    send(1'b1, 15'h0040, a5); drop_idle();
    send(1'b0, 15'h0040, '0); drop_idle();
    check_counters("wr_rd");
    send(1'b0, 15'h0080, '0); drop_idle();
    send(1'b0, 15'h0040, '0); drop_idle();

    // Valid held high with alternating addresses.
    for (int i = 0; i < 20; i++) send(1'b0, (i % 2 == 0) ? 15'h0040 : 15'h0080, '0);
    drop_idle();

    // Randomized mixed traffic over a small aliasing address set.
    for (int i = 0; i < 1000; i++) begin
      rw = ($urandom_range(0, 3) == 0);
      a  = AW'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
      send(rw, a, d);
      if ($urandom_range(0, 1) == 0) drop_idle();
    end
    drop_idle();
    check_counters("random");
    for (int v = 0; v < 8; v++) check($sformatf("lat_seen_%0d", v), LW'(lat_seen[v]), LW'(1));

    // Reset in the middle of an outstanding read.
    send(1'b0, 15'h0040, '0);
    mem_req_valid = 1'b0; held = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    exp_q.delete(); exp_cyc_q.delete();
    outstanding = 1'b0; have_prev = 1'b0;
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_busy = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", LW'(mem_req_ready), LW'(1));
    check("midrst_resp_valid", LW'(mem_resp_valid), LW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_ready", LW'(mem_req_ready), LW'(1));
    check_counters("postrst");
    send(1'b0, 15'h0040, '0); drop_idle();

    // Clear asserted in the completion cycle of a read.
    clear_stats();
    send(1'b0, 15'h0012, '0);
    mem_req_valid = 1'b0; held = 1'b0;
    w = 0;
    while (!mem_resp_valid && w < 100) begin @(negedge clk); w++; end
    if (!mem_resp_valid) begin
      checks++;
      $display("FAIL clr_resp_timeout: got resp_valid=0 expected 1");
    end
    clear_stats();
    check_counters("clr_coincident");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_model.md
MEM_MODEL -- requirements
Module: mem_model

Interface
REQ-001 Parameter ADDR_W, default 15, line address width; legal range 1..16.
REQ-002 Parameter LINE_W, default 256, line data width; must be a multiple of 32.
REQ-003 Parameter IDX_W, default 6, backing store holds 2**IDX_W lines, indexed by addr[IDX_W-1:0]; IDX_W <= ADDR_W.
REQ-004 Parameter LAT_MIN, default 20, base response latency in cycles; LAT_MIN >= 1.
REQ-005 Parameter JIT_EN, default 0, 1 = add pseudo-random jitter to latency.
REQ-006 Parameter JIT_W, default 3, jitter width; jitter range 0..2**JIT_W-1.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-009 mem_req_valid  in  1  request present.
REQ-010 mem_req_rw  in  1  1 = write line, 0 = read line.
REQ-011 mem_req_addr  in  ADDR_W  line address.
REQ-012 mem_req_wdata  in  LINE_W  write data.
REQ-013 mem_req_ready  out  1  model idle, can accept.
REQ-014 mem_resp_valid  out  1  one-cycle completion pulse.
REQ-015 mem_resp_rdata  out  LINE_W  read data, held until next completion.
REQ-016 stats_clr  in  1  synchronous clear of statistics counters.
REQ-017 rd_cnt, wr_cnt  out  16 each  completed reads / writes, saturating.
REQ-018 busy_cycles  out  32  cycles with a request outstanding, saturating.

Function
REQ-019 States IDLE and BUSY; request accepted in cycle T when mem_req_valid && mem_req_ready; valid without ready is ignored, with no side effects.
REQ-020 On accept: rw, addr, wdata and latency L latched; state -> BUSY; mem_req_ready low from T+1.
REQ-021 L = LAT_MIN when JIT_EN=0, else LAT_MIN + lfsr[JIT_W-1:0] sampled in cycle T; mem_resp_valid high exactly in cycle T+L, for one cycle.
REQ-022 State -> IDLE after the response cycle; mem_req_ready high from T+L+1; no request is accepted during the response cycle.
REQ-023 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances every cycle regardless of state.
REQ-024 Each line stores: data, full address tag, valid bit.
REQ-025 Write completion (cycle T+L): line[idx] <= {valid=1, tag=addr, data=wdata}; mem_resp_rdata <= wdata.
REQ-026 Read completion, line valid and tag == addr: mem_resp_rdata <= stored data.
REQ-027 Read completion otherwise (never written, or aliased index): mem_resp_rdata <= fill pattern; 32-bit word k = {k[7:0], 8'h00, addr zero-extended to 16 bits}.
REQ-028 Read data is taken after any earlier write completion; a read following a write to the same address returns the written data.
REQ-029 rd_cnt / wr_cnt increment in the completion cycle; they hold at 16'hFFFF.
REQ-030 busy_cycles increments each cycle state == BUSY; it holds at 32'hFFFFFFFF.
REQ-031 stats_clr zeroes all three counters next edge and has priority over a same-cycle increment; it does not affect the FSM or storage.

Reset
REQ-032 While rst_n=0: state IDLE, mem_req_ready=1, mem_resp_valid=0, mem_resp_rdata=0, all counters 0, LFSR=16'hACE1, all line valid bits 0.
REQ-033 Reset during BUSY abandons the request; no response is issued after release.
REQ-034 The first request can be accepted on the first rising edge after rst_n rises.

Verification
REQ-035 Default params, read addr 15'h0012 at T -> ready low T+1..T+20, resp_valid only at T+20, every word = 32'h0k000012 (k=0..7), rd_cnt=1.
REQ-036 Write addr 15'h0040, wdata all 32'hA5A5A5A5, then read 15'h0040 -> read rdata all A5A5A5A5, wr_cnt=1, rd_cnt=1, busy_cycles=40.
REQ-037 Write 15'h0040, then read alias 15'h0080 (same idx 0) -> fill pattern with addr 0080; a read of 15'h0040 still returns A5 data.
REQ-038 mem_req_valid held high continuously with alternating addresses -> accepts spaced exactly LAT_MIN+1 cycles; never two accepts within one latency window.
REQ-039 JIT_EN=1, JIT_W=3, 1000 reads -> each latency in 20..27, each value matches the reference LFSR model, every value observed.
REQ-040 rst_n low at T+10 of a read -> no resp_valid ever; ready=1 and counters 0 after release; stats_clr coincident with a completion -> counter reads 0.
